reg_file_arbiter: RTL and testbench
===================================

// Module: reg_file_arbiter
// PURPOSE
//  Shares the single-port 16x8 register file between two requesters:
//  requester 0 (core datapath) and requester 1 (loader/debug port).
//  Each requester issues read/write commands over a valid/ready handshake.
//  Accepted commands pass through a one-entry command stage that drives the register file.
//  Read data, or a write acknowledge, returns on a per-requester one-cycle response pulse.
// PARAMETERS
//  AW    4  register address width (16 registers)
//  DW    8  data width
//  FAIR  1  1 = round-robin between requesters, 0 = fixed priority (req0 always wins)
// PORTS
//  CLK          in   1   clock, all state on posedge
//  RST_N        in   1   reset, asynchronous, active-low
//  req0_valid   in   1   requester 0 command valid
//  req0_ready   out  1   requester 0 command accepted this cycle (combinational)
//  req0_we      in   1   1 = write, 0 = read
//  req0_reg     in   AW  target register
//  req0_wdata   in   DW  write data
//  rsp0_valid   out  1   one-cycle response pulse to requester 0
//  rsp0_rdata   out  DW  read data (read) or echoed write data (write)
//  req1_*/rsp1_*         same as req0_*/rsp0_*, for requester 1
//  rf_reg       out  AW  register file address (registered)
//  rf_wdata     out  DW  register file write data (registered)
//  rf_write     out  1   register file write enable (registered)
//  rf_rdata     in   DW  register file combinational read data for rf_reg
//  busy         out  1   command stage holds a command
// BEHAVIOUR
//  Reset (RST_N=0, takes effect immediately):
//   - clears the command stage; rf_reg/rf_wdata/rf_write/busy = 0.
//   - rsp*_valid = 0, rsp*_rdata = 0; round-robin pointer favours req0.
//   - reqN_ready = 0 while RST_N=0.
//   - A command in flight is dropped: no write, no response.
//  Arbitration (combinational, evaluated every cycle):
//   - only one valid -> that one is ready.
//   - both valid, FAIR=0 -> req0 ready, req1 not.
//   - both valid, FAIR=1 -> the pointer side is ready.
//   - After each accept, pointer := the other requester; with no accept the pointer holds.
//   - The stage accepts one command per cycle and never stalls. ready depends only on the valids and the pointer.
//  Handshake:
//   - Transfer occurs on a posedge with valid&&ready (edge E0).
//   - A requester holds valid, we, reg and wdata stable until ready.
//   - A requester may not drop valid before its command is accepted.
//  Pipeline:
//   - E0: the command stage loads {owner, we, reg, wdata}; busy=1.
//   - Cycle after E0: rf_* reflect the command; rf_write = we.
//   - E1: the register file writes (if we); rf_rdata is captured into rspN_rdata.
//   - For a write, rspN_rdata = wdata.
//   - After E1: rspN_valid=1 for one cycle (owner only). Latency = 2 edges accept->response.
//   - busy drops after E1 unless a new command was accepted at E1.
//   - rsp*_rdata holds its last value when rsp*_valid=0.
//  Ordering:
//   - Commands complete strictly in accept order.
//   - A read accepted at E1 behind a write to the same register returns the new data.
//   - No forwarding is needed: the write lands at E1, the read samples at E2.
//  Simultaneous:
//   - Both requesters target the same register in the same cycle: serialised by arbitration, loser goes second.
//   - Accept and completion in the same edge are legal (full throughput).
// TESTING
//  1. Reset: RST_N low during a write cycle -> rf_write=0 immediately; no rsp0_valid; all outputs 0.
//  2. req0 writes r3=0x16, then reads r3 -> rsp0_valid 2 edges after each accept; read rdata=0x16.
//  3. FAIR=1, both valid for 4 cycles with distinct regs -> accepts 0,1,0,1; rsp pulses alternate; no gap.
//  4. FAIR=0, both valid -> req1_ready=0 until req0_valid drops; then req1 is accepted that cycle.
//  5. req1 writes r5=0xBB, then req0 reads r5 the next cycle -> rsp0_rdata=0xBB.
//  6. Idle with no requests -> busy=0; rf_write=0; pointer unchanged; no rsp pulses.

Source files
------------

// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter in front of a single-port register file.
// One-entry command stage; responses return two edges after acceptance.
module reg_file_arbiter #(
    parameter int unsigned AW   = 4,
    parameter int unsigned DW   = 8,
    parameter bit          FAIR = 1'b1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_reg,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_reg,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] rf_reg,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_write,
    input  logic [DW-1:0] rf_rdata,
    output logic          busy
);

    logic          st_valid_q;
    logic          st_owner_q;
    logic          st_we_q;
    logic [AW-1:0] st_reg_q;
    logic [DW-1:0] st_wdata_q;
    // 0 favours req0, 1 favours req1
    logic          ptr_q;
    logic          grant0;
    logic          grant1;
    logic [DW-1:0] rsp_data;

    always_comb begin
        grant0 = RST_N && req0_valid && (!req1_valid || !FAIR || !ptr_q);
        grant1 = RST_N && req1_valid && (!req0_valid || (FAIR && ptr_q));
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rf_reg     = st_reg_q;
    assign rf_wdata   = st_wdata_q;
    assign rf_write   = st_valid_q && st_we_q;
    assign busy       = st_valid_q;
    assign rsp_data   = st_we_q ? st_wdata_q : rf_rdata;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_valid_q <= 1'b0;
            st_owner_q <= 1'b0;
            st_we_q    <= 1'b0;
            st_reg_q   <= '0;
            st_wdata_q <= '0;
            ptr_q      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            // Completion of the staged command (register file writes on this same edge)
            rsp0_valid <= st_valid_q && !st_owner_q;
            rsp1_valid <= st_valid_q && st_owner_q;
            if (st_valid_q && !st_owner_q) rsp0_rdata <= rsp_data;
            if (st_valid_q && st_owner_q)  rsp1_rdata <= rsp_data;

            st_valid_q <= grant0 || grant1;
            if (grant0) begin
                st_owner_q <= 1'b0;
                st_we_q    <= req0_we;
                st_reg_q   <= req0_reg;
                st_wdata_q <= req0_wdata;
            end else if (grant1) begin
                st_owner_q <= 1'b1;
                st_we_q    <= req1_we;
                st_reg_q   <= req1_reg;
                st_wdata_q <= req1_wdata;
            end
            if (grant0 || grant1) ptr_q <= grant0;
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_reg_file_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    always #5 CLK = ~CLK;

    // Round-robin instance
    logic       req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [3:0] req0_reg = 0, req1_reg = 0;
    logic [7:0] req0_wdata = 0, req1_wdata = 0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_write, busy;
    logic [7:0] rsp0_rdata, rsp1_rdata, rf_wdata, rf_rdata;
    logic [3:0] rf_reg;
    logic [7:0] mem [16] = '{default: 8'h00};

    always @(posedge CLK) if (rf_write) mem[rf_reg] <= rf_wdata;
    assign rf_rdata = mem[rf_reg];

    reg_file_arbiter #(.AW(4), .DW(8), .FAIR(1'b1)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_reg(req0_reg), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_reg(req1_reg), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .rf_reg(rf_reg), .rf_wdata(rf_wdata), .rf_write(rf_write), .rf_rdata(rf_rdata),
        .busy(busy)
    );

    // Fixed-priority instance
    logic       f0_valid = 0, f1_valid = 0;
    logic [3:0] f0_reg = 0, f1_reg = 0;
    logic [7:0] f0_wdata = 0, f1_wdata = 0;
    logic       f0_ready, f1_ready, f_rsp0_valid, f_rsp1_valid, f_rf_write, f_busy;
    logic [7:0] f_rsp0_rdata, f_rsp1_rdata, f_rf_wdata, f_rf_rdata;
    logic [3:0] f_rf_reg;
    logic [7:0] fmem [16] = '{default: 8'h00};

    always @(posedge CLK) if (f_rf_write) fmem[f_rf_reg] <= f_rf_wdata;
    assign f_rf_rdata = fmem[f_rf_reg];

    reg_file_arbiter #(.AW(4), .DW(8), .FAIR(1'b0)) u_fp (
        .CLK(CLK), .RST_N(RST_N),
        .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_we(1'b1),
        .req0_reg(f0_reg), .req0_wdata(f0_wdata),
        .rsp0_valid(f_rsp0_valid), .rsp0_rdata(f_rsp0_rdata),
        .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_we(1'b1),
        .req1_reg(f1_reg), .req1_wdata(f1_wdata),
        .rsp1_valid(f_rsp1_valid), .rsp1_rdata(f_rsp1_rdata),
        .rf_reg(f_rf_reg), .rf_wdata(f_rf_wdata), .rf_write(f_rf_write),
        .rf_rdata(f_rf_rdata), .busy(f_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model of the round-robin instance
    logic       m_ptr;
    logic       p_valid, p_owner, p_we;
    logic [3:0] p_reg;
    logic [7:0] p_wdata;
    logic       e_rsp0, e_rsp1;
    logic [7:0] e_rdata0, e_rdata1;
    logic [7:0] m_mem [16] = '{default: 8'h00};

    function automatic logic exp_g0();
        return RST_N && req0_valid && (!req1_valid || m_ptr == 1'b0);
    endfunction

    function automatic logic exp_g1();
        return RST_N && req1_valid && (!req0_valid || m_ptr == 1'b1);
    endfunction

    task automatic model_reset();
        m_ptr = 0; p_valid = 0; p_owner = 0; p_we = 0; p_reg = 0; p_wdata = 0;
        e_rsp0 = 0; e_rsp1 = 0; e_rdata0 = 0; e_rdata1 = 0;
    endtask

    // One clock: model the edge from the current inputs, end at the next negedge
    task automatic tick();
        logic g0, g1;
        logic [7:0] d;
        g0 = exp_g0();
        g1 = exp_g1();
        @(posedge CLK);
        e_rsp0 = 0;
        e_rsp1 = 0;
        if (p_valid) begin
            if (p_we) begin
                m_mem[p_reg] = p_wdata;
                d = p_wdata;
            end else begin
                d = m_mem[p_reg];
            end
            if (p_owner) begin e_rsp1 = 1; e_rdata1 = d; end
            else begin e_rsp0 = 1; e_rdata0 = d; end
        end
        p_valid = g0 || g1;
        if (g0) begin p_owner = 0; p_we = req0_we; p_reg = req0_reg; p_wdata = req0_wdata; end
        else if (g1) begin p_owner = 1; p_we = req1_we; p_reg = req1_reg; p_wdata = req1_wdata; end
        if (g0) m_ptr = 1;
        else if (g1) m_ptr = 0;
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RST_N = 0;
        req0_valid = 0; req1_valid = 0; f0_valid = 0; f1_valid = 0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        n_cmp++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_write, busy} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b exp 000000",
                {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_write, busy}); end
        n_cmp++; if ({rsp0_rdata, rsp1_rdata, rf_wdata, rf_reg} !== 28'h0) begin
            n_err++; $display("FAIL reset_data got %h exp 0", {rsp0_rdata, rsp1_rdata, rf_wdata, rf_reg}); end
        @(negedge CLK);
        RST_N = 1;
        req0_valid = 1; req0_we = 1; req0_reg = 4'd7; req0_wdata = 8'hAA;
        tick();
        n_cmp++; if (rf_write !== 1'b1 || rf_reg !== 4'd7) begin
            n_err++; $display("FAIL reset_staged got we=%b reg=%0d exp we=1 reg=7", rf_write, rf_reg); end
        #2 RST_N = 0;
        #1;
        n_cmp++; if (rf_write !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_drop got we=%b busy=%b exp 0 0", rf_write, busy); end
        n_cmp++; if (req0_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready got %b exp 0", req0_ready); end
        req0_valid = 0;
        @(posedge CLK);
        @(negedge CLK);
        n_cmp++; if (rsp0_valid !== 1'b0 || mem[7] !== 8'h00) begin
            n_err++; $display("FAIL reset_no_write got rsp=%b mem7=%h exp 0 00", rsp0_valid, mem[7]); end
        RST_N = 1;
        model_reset();
    endtask

    task automatic test_write_read();
        req0_valid = 1; req0_we = 1; req0_reg = 4'd3; req0_wdata = 8'h16;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin
            n_err++; $display("FAIL wr_ready got %b exp 1", req0_ready); end
        tick();
        n_cmp++; if (rsp0_valid !== 1'b0) begin
            n_err++; $display("FAIL wr_early_rsp got %b exp 0", rsp0_valid); end
        req0_we = 0; req0_wdata = 8'h00;
        tick();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'h16) begin
            n_err++; $display("FAIL wr_rsp got v=%b d=%h exp 1 16", rsp0_valid, rsp0_rdata); end
        req0_valid = 0;
        tick();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'h16 || rsp0_rdata !== e_rdata0) begin
            n_err++; $display("FAIL rd_rsp got v=%b d=%h exp 1 16", rsp0_valid, rsp0_rdata); end
        tick();
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== 8'h16 || busy !== 1'b0) begin
            n_err++; $display("FAIL rd_hold got v=%b d=%h busy=%b exp 0 16 0", rsp0_valid, rsp0_rdata, busy); end
    endtask

    task automatic test_fair_alternate();
        int a0, a1;
        apply_reset();
        a0 = 0; a1 = 0;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req0_we = 1; req0_reg = 4'(a0); req0_wdata = 8'(8'h20 + a0);
            req1_valid = 1; req1_we = 1; req1_reg = 4'(8 + a1); req1_wdata = 8'(8'h30 + a1);
            #1;
            n_cmp++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                n_err++; $display("FAIL rr_ready[%0d] got %b%b exp %b%b", i, req0_ready, req1_ready,
                    i % 2 == 0, i % 2 == 1); end
            tick();
            if (i % 2 == 0) a0++; else a1++;
            if (i > 0) begin
                n_cmp++; if (rsp0_valid !== ((i - 1) % 2 == 0) || rsp1_valid !== ((i - 1) % 2 == 1)
                             || busy !== 1'b1) begin
                    n_err++; $display("FAIL rr_rsp[%0d] got %b%b busy=%b exp %b%b 1", i, rsp0_valid,
                        rsp1_valid, busy, (i - 1) % 2 == 0, (i - 1) % 2 == 1); end
            end
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 8'h31) begin
            n_err++; $display("FAIL rr_last got v=%b d=%h exp 1 31", rsp1_valid, rsp1_rdata); end
        tick();
    endtask

    task automatic test_fixed_priority();
        f1_valid = 1; f1_reg = 4'd11; f1_wdata = 8'h5C;
        for (int i = 0; i < 3; i++) begin
            f0_valid = 1; f0_reg = 4'(8 + i); f0_wdata = 8'(8'h40 + i);
            #1;
            n_cmp++; if (f0_ready !== 1'b1 || f1_ready !== 1'b0) begin
                n_err++; $display("FAIL fp_ready[%0d] got %b%b exp 10", i, f0_ready, f1_ready); end
            tick();
            if (i > 0) begin
                n_cmp++; if (f_rsp0_valid !== 1'b1 || f_rsp0_rdata !== 8'(8'h40 + i - 1)) begin
                    n_err++; $display("FAIL fp_rsp0[%0d] got v=%b d=%h exp 1 %h", i, f_rsp0_valid,
                        f_rsp0_rdata, 8'(8'h40 + i - 1)); end
            end
        end
        f0_valid = 0;
        #1;
        n_cmp++; if (f0_ready !== 1'b0 || f1_ready !== 1'b1) begin
            n_err++; $display("FAIL fp_release got %b%b exp 01", f0_ready, f1_ready); end
        tick();
        f1_valid = 0;
        tick();
        n_cmp++; if (f_rsp1_valid !== 1'b1 || f_rsp1_rdata !== 8'h5C || fmem[11] !== 8'h5C) begin
            n_err++; $display("FAIL fp_rsp1 got v=%b d=%h mem=%h exp 1 5c 5c", f_rsp1_valid,
                f_rsp1_rdata, fmem[11]); end
        tick();
    endtask

    task automatic test_cross_requester();
        req1_valid = 1; req1_we = 1; req1_reg = 4'd5; req1_wdata = 8'hBB;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin
            n_err++; $display("FAIL x_ready got %b exp 1", req1_ready); end
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_we = 0; req0_reg = 4'd5;
        tick();
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 8'hBB) begin
            n_err++; $display("FAIL x_wr_rsp got v=%b d=%h exp 1 bb", rsp1_valid, rsp1_rdata); end
        req0_valid = 0;
        tick();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'hBB) begin
            n_err++; $display("FAIL x_rd_rsp got v=%b d=%h exp 1 bb", rsp0_valid, rsp0_rdata); end
    endtask

    task automatic test_idle();
        logic saved;
        saved = m_ptr;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if ({busy, rf_write, rsp0_valid, rsp1_valid} !== 4'b0) begin
                n_err++; $display("FAIL idle[%0d] got %b exp 0000", i,
                    {busy, rf_write, rsp0_valid, rsp1_valid}); end
        end
        req0_valid = 1; req0_we = 1; req0_reg = 4'd12; req0_wdata = 8'h66;
        req1_valid = 1; req1_we = 1; req1_reg = 4'd13; req1_wdata = 8'h77;
        #1;
        n_cmp++; if (req0_ready !== (saved == 1'b0) || req1_ready !== (saved == 1'b1)) begin
            n_err++; $display("FAIL idle_ptr got %b%b exp %b%b", req0_ready, req1_ready,
                saved == 1'b0, saved == 1'b1); end
        tick();
        if (saved == 1'b0) req0_valid = 0; else req1_valid = 0;
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic a0, a1;
        for (int i = 0; i < 400; i++) begin
            #1;
            n_cmp++; if (req0_ready !== exp_g0() || req1_ready !== exp_g1()) begin
                n_err++; $display("FAIL rnd_ready[%0d] got %b%b exp %b%b", i, req0_ready,
                    req1_ready, exp_g0(), exp_g1()); end
            a0 = exp_g0();
            a1 = exp_g1();
            tick();
            n_cmp++; if (rsp0_valid !== e_rsp0 || rsp0_rdata !== e_rdata0) begin
                n_err++; $display("FAIL rnd_rsp0[%0d] got v=%b d=%h exp %b %h", i, rsp0_valid,
                    rsp0_rdata, e_rsp0, e_rdata0); end
            n_cmp++; if (rsp1_valid !== e_rsp1 || rsp1_rdata !== e_rdata1) begin
                n_err++; $display("FAIL rnd_rsp1[%0d] got v=%b d=%h exp %b %h", i, rsp1_valid,
                    rsp1_rdata, e_rsp1, e_rdata1); end
            n_cmp++; if (busy !== p_valid || rf_write !== (p_valid && p_we)) begin
                n_err++; $display("FAIL rnd_stage[%0d] got busy=%b we=%b exp %b %b", i, busy,
                    rf_write, p_valid, p_valid && p_we); end
            // A requester only changes its command once the current one is accepted
            if (a0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_we = $urandom_range(0, 1) == 1;
                req0_reg = 4'($urandom_range(0, 3));
                req0_wdata = 8'($urandom);
            end
            if (a1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_we = $urandom_range(0, 1) == 1;
                req1_reg = 4'($urandom_range(0, 3));
                req1_wdata = 8'($urandom);
            end
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fair_alternate();
        test_fixed_priority();
        test_cross_requester();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
